capp_search_ctrl: RTL and testbench
===================================

Name: capp_search_ctrl

Overview:
- Sequencer for the CAPP comparand/mask search datapath.
- Accepts search and tag-manipulation commands over a valid/ready handshake, then drives comparand, mask and perform_search to the compare array for a fixed settle time.
- Captures the per-cell match lines into a persistent tag register and serially scans it to produce a match count and the lowest matching cell index.
- Sits between the host/command sequencer and the compare array plus cell match logic.

Parameters:
WIDTH, 32, comparand/mask width in bits
CELLS, 16, number of CAPP cells (match lines); must be >= 2
SETTLE_CYCLES, 1, cycles perform_search is held before match lines are sampled; must be >= 1

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  0=SEARCH, 1=SEARCH_AND (refine existing tags), 2=CLEAR_TAGS, 3=SET_TAGS
cmd_comparand  in  WIDTH  comparand for SEARCH/SEARCH_AND
cmd_mask  in  WIDTH  mask for SEARCH/SEARCH_AND (1 = bit participates)
comparand  out  WIDTH  registered comparand to array
mask  out  WIDTH  registered mask to array
perform_search  out  1  array search enable
match_in  in  CELLS  per-cell match result from array (1 = match)
tags  out  CELLS  current tag register
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed
rsp_count  out  $clog2(CELLS+1)  number of set tags
rsp_first  out  $clog2(CELLS)  lowest set tag index; 0 if none
rsp_any  out  1  at least one tag set

Behaviour:
- Reset (async, RST_N=0): state IDLE; comparand, mask, tags, rsp_count, rsp_first, rsp_any = 0; perform_search=0; rsp_valid=0; cmd_ready=1 once released. Reset mid-operation aborts the command with no response.
- States: IDLE, DRIVE, SCAN, RESP.
- IDLE: cmd_ready=1; no other state asserts cmd_ready. Accept on cmd_valid&&cmd_ready at a clock edge.
  - Ops 0/1: latch comparand/mask outputs; go to DRIVE.
  - Op 2: tags<=0 on the accept edge. Op 3: tags<=all ones on the accept edge. Both go to SCAN; comparand/mask are unchanged.
- DRIVE: perform_search=1 for exactly SETTLE_CYCLES cycles. On the edge ending the last cycle, capture tags:
  - SEARCH: tags <= match_in.
  - SEARCH_AND: tags <= tags & match_in.
  - Go to SCAN.
- SCAN: exactly CELLS cycles; index i = 0..CELLS-1, one bit per cycle, lowest first.
  - Count accumulator cleared on SCAN entry; increments when tags[i]=1.
  - First-index register latched at the first set bit only.
  - Go to RESP after index CELLS-1.
- RESP: rsp_valid=1; rsp_count/rsp_first/rsp_any are registered and stable while rsp_valid=1. On rsp_valid&&rsp_ready, return to IDLE; the next command can be accepted on the following edge.
- Latency (accept edge to first rsp_valid cycle):
  - Ops 0/1: SETTLE_CYCLES+CELLS+1 (18 at defaults).
  - Ops 2/3: CELLS+1 (17 at defaults).
- comparand/mask hold their last values outside DRIVE.
- tags persist across commands; they change only on capture, op 2/3, or reset.
- Mask = 0 is a legal search: the array reports all cells matching, and the controller does not special-case it.
- No tags set: rsp_count=0, rsp_any=0, rsp_first=0. All set: rsp_count=CELLS (16 fits in 5 bits).
- cmd_* is ignored outside IDLE. rsp_ready is ignored outside RESP.

Optional Feature:
- Macro CAPP_SEARCH_PERF_CNT_EN.
- When defined: extra output search_cnt, 16 bits, reset to 0.
  - Increments on each accepted op 0/1.
  - Saturates at 16'hFFFF.
  - Ops 2/3 do not count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then SEARCH, comparand=32'hA5A5A5A5, mask=32'hFFFFFFFF, match_in=16'h0090 -> perform_search high exactly 1 cycle with outputs A5A5A5A5/FFFFFFFF; rsp_valid 18 cycles after accept; count=2, first=4, any=1, tags=0090.
- SEARCH_AND after the previous test with match_in=16'h0810 -> tags=0010, count=1, first=4.
- CLEAR_TAGS -> rsp after 17 cycles, count=0, first=0, any=0, tags=0000, perform_search never asserted. SET_TAGS -> count=16, first=0, any=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, cmd_ready=0 throughout; new cmd_valid is accepted only on the edge after the rsp handshake.
- Assert RST_N=0 mid-SCAN -> immediately rsp_valid=0, tags=0, perform_search=0, state IDLE; a subsequent SEARCH completes normally with 18-cycle latency.
- With CAPP_SEARCH_PERF_CNT_EN: 3 SEARCH + 1 CLEAR -> search_cnt=3; preload 16'hFFFF via force and issue SEARCH -> remains 16'hFFFF.

Source files
------------

// File: rtl/capp_search_ctrl.sv
// CAPP comparand/mask search sequencer: drives the compare array, captures match lines into tags, scans for count/first.
// Optional build macro CAPP_SEARCH_PERF_CNT_EN adds a saturating 16-bit search_cnt output.
module capp_search_ctrl #(
    parameter int WIDTH         = 32,
    parameter int CELLS         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_comparand,
    input  logic [WIDTH-1:0]           cmd_mask,
    output logic [WIDTH-1:0]           comparand,
    output logic [WIDTH-1:0]           mask,
    output logic                       perform_search,
    input  logic [CELLS-1:0]           match_in,
    output logic [CELLS-1:0]           tags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(CELLS+1)-1:0] rsp_count,
    output logic [$clog2(CELLS)-1:0]   rsp_first,
    output logic                       rsp_any
`ifdef CAPP_SEARCH_PERF_CNT_EN
    ,
    output logic [15:0]                search_cnt
`endif
);

    localparam int CW = $clog2(CELLS + 1);
    localparam int IW = $clog2(CELLS);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SCAN,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] comparand_q, comparand_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CELLS-1:0] tags_q, tags_d;
    logic             refine_q, refine_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    first_q, first_d;
    logic             found_q, found_d;
    logic [CW-1:0]    rsp_count_q, rsp_count_d;
    logic [IW-1:0]    rsp_first_q, rsp_first_d;
    logic             rsp_any_q, rsp_any_d;

    logic             cmd_accept;
    logic             bit_set;
    logic [CW-1:0]    acc_inc;
    logic [CELLS-1:0] capture_vec;

    // SEARCH_AND keeps a cell only if it was already tagged; plain SEARCH takes match_in as is.
    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_capture
            assign capture_vec[gi] = match_in[gi] & (tags_q[gi] | ~refine_q);
        end
    endgenerate

    assign cmd_accept = cmd_valid && (state_q == ST_IDLE);
    assign bit_set    = tags_q[idx_q];
    assign acc_inc    = acc_q + CW'(bit_set);

    always_comb begin
        state_d     = state_q;
        comparand_d = comparand_q;
        mask_d      = mask_q;
        tags_d      = tags_q;
        refine_d    = refine_q;
        settle_d    = settle_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        first_d     = first_q;
        found_d     = found_q;
        rsp_count_d = rsp_count_q;
        rsp_first_d = rsp_first_q;
        rsp_any_d   = rsp_any_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (!cmd_op[1]) begin
                        comparand_d = cmd_comparand;
                        mask_d      = cmd_mask;
                        refine_d    = cmd_op[0];
                        settle_d    = '0;
                        state_d     = ST_DRIVE;
                    end else begin
                        tags_d  = cmd_op[0] ? '1 : '0;
                        idx_d   = '0;
                        acc_d   = '0;
                        first_d = '0;
                        found_d = 1'b0;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    tags_d  = capture_vec;
                    idx_d   = '0;
                    acc_d   = '0;
                    first_d = '0;
                    found_d = 1'b0;
                    state_d = ST_SCAN;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_SCAN: begin
                if (bit_set && !found_q) begin
                    first_d = idx_q;
                    found_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    // Fold the final bit in directly so the result is ready on RESP entry.
                    rsp_count_d = acc_inc;
                    rsp_first_d = found_q ? first_q : (bit_set ? idx_q : '0);
                    rsp_any_d   = found_q | bit_set;
                    state_d     = ST_RESP;
                end else begin
                    idx_d = idx_q + IW'(1);
                    acc_d = acc_inc;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            comparand_q <= '0;
            mask_q      <= '0;
            tags_q      <= '0;
            refine_q    <= 1'b0;
            settle_q    <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            first_q     <= '0;
            found_q     <= 1'b0;
            rsp_count_q <= '0;
            rsp_first_q <= '0;
            rsp_any_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            comparand_q <= comparand_d;
            mask_q      <= mask_d;
            tags_q      <= tags_d;
            refine_q    <= refine_d;
            settle_q    <= settle_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            found_q     <= found_d;
            rsp_count_q <= rsp_count_d;
            rsp_first_q <= rsp_first_d;
            rsp_any_q   <= rsp_any_d;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign perform_search = (state_q == ST_DRIVE);
    assign rsp_valid      = (state_q == ST_RESP);
    assign comparand      = comparand_q;
    assign mask           = mask_q;
    assign tags           = tags_q;
    assign rsp_count      = rsp_count_q;
    assign rsp_first      = rsp_first_q;
    assign rsp_any        = rsp_any_q;

`ifdef CAPP_SEARCH_PERF_CNT_EN
    logic [15:0] search_cnt_q, search_cnt_d;

    always_comb begin
        search_cnt_d = search_cnt_q;
        if (cmd_accept && !cmd_op[1] && (search_cnt_q != 16'hFFFF)) begin
            search_cnt_d = search_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            search_cnt_q <= '0;
        end else begin
            search_cnt_q <= search_cnt_d;
        end
    end

    assign search_cnt = search_cnt_q;
`endif

endmodule

// File: tb/tb_capp_search_ctrl.sv
// Testbench for capp_search_ctrl: directed vector table, hand sequences for backpressure/reset, and random commands vs. a tag model.
module tb_capp_search_ctrl;

    localparam int WIDTH  = 32;
    localparam int CELLS  = 16;
    localparam int SETTLE = 1;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_comparand;
    logic [WIDTH-1:0]  cmd_mask;
    logic [WIDTH-1:0]  comparand;
    logic [WIDTH-1:0]  mask;
    logic              perform_search;
    logic [CELLS-1:0]  match_in;
    logic [CELLS-1:0]  tags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [4:0]        rsp_count;
    logic [3:0]        rsp_first;
    logic              rsp_any;
`ifdef CAPP_SEARCH_PERF_CNT_EN
    logic [15:0]       search_cnt;
`endif

    capp_search_ctrl #(.WIDTH(WIDTH), .CELLS(CELLS), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_comparand(cmd_comparand), .cmd_mask(cmd_mask),
        .comparand(comparand), .mask(mask), .perform_search(perform_search),
        .match_in(match_in), .tags(tags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_count(rsp_count), .rsp_first(rsp_first), .rsp_any(rsp_any)
`ifdef CAPP_SEARCH_PERF_CNT_EN
        , .search_cnt(search_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: tag vector and last driven comparand/mask.
    logic [CELLS-1:0] m_tags;
    logic [WIDTH-1:0] m_comp, m_mask;

    task automatic model_step(input logic [1:0] op, input logic [WIDTH-1:0] c,
                              input logic [WIDTH-1:0] k, input logic [CELLS-1:0] match);
        case (op)
            2'd0: begin m_tags = match;          m_comp = c; m_mask = k; end
            2'd1: begin m_tags = m_tags & match; m_comp = c; m_mask = k; end
            2'd2: m_tags = '0;
            default: m_tags = '1;
        endcase
    endtask

    function automatic int m_count(input logic [CELLS-1:0] t);
        int n = 0;
        for (int i = 0; i < CELLS; i++) n += int'(t[i]);
        return n;
    endfunction

    function automatic int m_first(input logic [CELLS-1:0] t);
        for (int i = 0; i < CELLS; i++) if (t[i]) return i;
        return 0;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] k,
                           input logic [CELLS-1:0] match, input int hold,
                           input logic [CELLS-1:0] e_tags, input int e_count, input int e_first,
                           input logic e_any);
        int lat, ps_cnt, guard;
        logic ready_seen;
        logic [63:0] snap;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = op; cmd_comparand = c; cmd_mask = k; match_in = match;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge CLK); guard++; end
        check("accept_ready", cmd_ready, 1);
        @(posedge CLK); #1;
        // Junk on the command bus while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom);
        cmd_comparand = $urandom; cmd_mask = $urandom;
        lat = 0; ps_cnt = 0; ready_seen = 1'b0;
        do begin
            @(negedge CLK);
            lat++;
            if (perform_search) begin
                ps_cnt++;
                check("drive_comparand", comparand, c);
                check("drive_mask", mask, k);
            end
            if (cmd_ready) ready_seen = 1'b1;
        end while (!rsp_valid && lat < 100);
        cmd_valid = 1'b0;
        check("latency", lat, op[1] ? CELLS + 1 : SETTLE + CELLS + 1);
        check("perform_search_cycles", ps_cnt, op[1] ? 0 : SETTLE);
        check("cmd_ready_low_busy", ready_seen, 0);
        check("tags", tags, e_tags);
        check("rsp_count", rsp_count, e_count);
        check("rsp_first", rsp_first, e_first);
        check("rsp_any", rsp_any, e_any);
        check("comparand_hold", comparand, m_comp);
        check("mask_hold", mask, m_mask);
        snap = {36'd0, rsp_count, rsp_first, rsp_any, tags, cmd_ready, rsp_valid};
        if (hold > 0) begin
            cmd_valid = 1'b1;
            cmd_op = (e_tags == '0) ? 2'd3 : 2'd2;
        end
        repeat (hold) begin
            @(negedge CLK);
            check("resp_stable", {36'd0, rsp_count, rsp_first, rsp_any, tags, cmd_ready, rsp_valid}, snap);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        check("handshake_to_idle", {rsp_valid, cmd_ready}, 2'b01);
        check("cmd_ignored_in_resp", tags, e_tags);
        cmd_valid = 1'b0;
        $display("txn op=%0d comp=%08h mask=%08h match=%04h hold=%0d -> tags=%04h count=%0d first=%0d any=%0d lat=%0d",
                 op, c, k, match, hold, tags, rsp_count, rsp_first, rsp_any, lat);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] k;
        logic [CELLS-1:0] match;
        int               hold;
        logic [CELLS-1:0] e_tags;
        int               e_count;
        int               e_first;
        logic             e_any;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 16'h0090, 0, 16'h0090, 2,  4,  1'b1};
        vecs[1] = '{2'd1, 32'h5A5A0000, 32'hFFFF0000, 16'h0810, 5, 16'h0010, 1,  4,  1'b1};
        vecs[2] = '{2'd2, 32'h11111111, 32'h22222222, 16'hFFFF, 0, 16'h0000, 0,  0,  1'b0};
        vecs[3] = '{2'd3, 32'h33333333, 32'h44444444, 16'h0000, 2, 16'hFFFF, 16, 0,  1'b1};
        vecs[4] = '{2'd0, 32'hDEADBEEF, 32'h00000000, 16'hFFFF, 0, 16'hFFFF, 16, 0,  1'b1};
        vecs[5] = '{2'd1, 32'h0F0F0F0F, 32'h0000FFFF, 16'h8001, 1, 16'h8001, 2,  0,  1'b1};
        vecs[6] = '{2'd0, 32'h12345678, 32'hFFFFFFFF, 16'h8000, 0, 16'h8000, 1,  15, 1'b1};
        vecs[7] = '{2'd1, 32'h87654321, 32'hFFFFFFFF, 16'h0001, 3, 16'h0000, 0,  0,  1'b0};

        RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_comparand = '0; cmd_mask = '0;
        match_in = '0; rsp_ready = 1'b0;
        m_tags = '0; m_comp = '0; m_mask = '0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_perform_search", perform_search, 0);
        check("reset_tags", tags, 0);
        check("reset_comparand", comparand, 0);
        check("reset_mask", mask, 0);
        check("reset_rsp", {rsp_count, rsp_first, rsp_any}, 0);

        for (int i = 0; i < 8; i++) begin
            model_step(vecs[i].op, vecs[i].c, vecs[i].k, vecs[i].match);
            run_cmd(vecs[i].op, vecs[i].c, vecs[i].k, vecs[i].match, vecs[i].hold,
                    vecs[i].e_tags, vecs[i].e_count, vecs[i].e_first, vecs[i].e_any);
        end

        // Reset in the middle of a scan aborts the command.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_comparand = 32'hCAFEF00D; cmd_mask = 32'hFFFF0000;
        match_in = 16'h00F0;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge CLK);
        check("pre_reset_tags", tags, 16'h00F0);
        RST_N = 1'b0;
        #1;
        check("midscan_rst_rsp_valid", rsp_valid, 0);
        check("midscan_rst_tags", tags, 0);
        check("midscan_rst_perform_search", perform_search, 0);
        check("midscan_rst_cmd_ready", cmd_ready, 1);
        check("midscan_rst_comparand", comparand, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        m_tags = '0; m_comp = '0; m_mask = '0;
        model_step(2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 16'h0090);
        run_cmd(2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 16'h0090, 0, m_tags, m_count(m_tags), m_first(m_tags), |m_tags);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]       op;
            logic [WIDTH-1:0] c, k;
            logic [CELLS-1:0] match;
            op    = 2'($urandom_range(0, 3));
            c     = $urandom;
            k     = $urandom;
            match = 16'($urandom);
            if (n % 5 == 0) match = 16'($urandom) & 16'($urandom) & 16'($urandom);
            model_step(op, c, k, match);
            run_cmd(op, c, k, match, $urandom_range(0, 2), m_tags, m_count(m_tags), m_first(m_tags), |m_tags);
        end

`ifdef CAPP_SEARCH_PERF_CNT_EN
        begin
            logic [15:0] base;
            base = search_cnt;
            for (int j = 0; j < 4; j++) begin
                logic [1:0] op;
                op = (j == 3) ? 2'd2 : 2'd0;
                model_step(op, 32'h1000 + j, 32'hFFFFFFFF, 16'h0101);
                run_cmd(op, 32'h1000 + j, 32'hFFFFFFFF, 16'h0101, 0, m_tags, m_count(m_tags), m_first(m_tags), |m_tags);
            end
            check("search_cnt_delta", search_cnt - base, 3);
            @(negedge CLK);
            force dut.search_cnt_q = 16'hFFFF;
            @(posedge CLK); #1;
            release dut.search_cnt_q;
            model_step(2'd0, 32'h0, 32'h0, 16'hFFFF);
            run_cmd(2'd0, 32'h0, 32'h0, 16'hFFFF, 0, m_tags, m_count(m_tags), m_first(m_tags), |m_tags);
            check("search_cnt_saturate", search_cnt, 16'hFFFF);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
